select_encode_seq: RTL and testbench

- Parametrised, registered successor to the register select/encode stage.
- Latches the instruction word and decodes the Ra/Rb/Rc fields into one-hot GPR read/write enables for NUM_REGS registers.
- Sign-extends the immediate field to datapath width.
- Adds a built-in sequencer: one control-unit request steps through Rb-read, Rc-read and Ra-write on successive cycles.
- Sits between the control unit and the register file.

---
 rtl/select_encode_seq_pkg.sv | 42 ++++
 rtl/select_encode_seq_dec_onehot.sv | 15 +
 rtl/select_encode_seq.sv | 158 +++++++++++++++
 tb/tb_select_encode_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/select_encode_seq_pkg.sv
// Shared types and constants for the register select/encode stage and its field sequencer.
package select_encode_seq_pkg;

    localparam int OPCODE_W     = 5;
    localparam int DEF_REG_SIZE = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_CONST_W  = 19;

    localparam int MASK_RB = 0;
    localparam int MASK_RC = 1;
    localparam int MASK_RA = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH_RB = 2'd1,
        PH_RC = 2'd2,
        PH_RA = 2'd3
    } seq_state_t;

    // First enabled phase strictly after cur, in RB -> RC -> RA order; IDLE when none remain.
    function automatic seq_state_t next_phase(input seq_state_t cur, input logic [2:0] mask);
        seq_state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE: begin
                if (mask[MASK_RB])      nxt = PH_RB;
                else if (mask[MASK_RC]) nxt = PH_RC;
                else if (mask[MASK_RA]) nxt = PH_RA;
            end
            PH_RB: begin
                if (mask[MASK_RC])      nxt = PH_RC;
                else if (mask[MASK_RA]) nxt = PH_RA;
            end
            PH_RC: begin
                if (mask[MASK_RA])      nxt = PH_RA;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/select_encode_seq_dec_onehot.sv
// Binary register index to one-hot enable decoder (NUM_REGS must equal 2**RW).
module dec_onehot #(
    parameter int RW       = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [RW-1:0]       sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/select_encode_seq.sv
// Registered register select/encode stage with a built-in Rb-read / Rc-read / Ra-write sequencer.
// Optional macro SELECT_ENCODE_ZEXT_EN adds c_zext to choose zero-extension of the immediate.
module select_encode_seq
    import select_encode_seq_pkg::*;
#(
    parameter int REG_SIZE = DEF_REG_SIZE,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CONST_W  = DEF_CONST_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [REG_SIZE-1:0] ir,
    input  logic                ir_ld,
`ifdef SELECT_ENCODE_ZEXT_EN
    input  logic                c_zext,
`endif
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                r_in,
    input  logic                r_out,
    input  logic                ba_out,
    input  logic                seq_req,
    input  logic [2:0]          seq_mask,
    output logic [NUM_REGS-1:0] gpr_in,
    output logic [NUM_REGS-1:0] gpr_out,
    output logic                r0_zero,
    output logic [REG_SIZE-1:0] c_se,
    output logic                seq_busy,
    output logic                seq_done
);

    localparam int RW    = $clog2(NUM_REGS);
    localparam int RA_HI = REG_SIZE - OPCODE_W - 1;
    localparam int RB_HI = RA_HI - RW;
    localparam int RC_HI = RB_HI - RW;

    seq_state_t          state, state_nxt;
    logic [REG_SIZE-1:0] ir_q, ir_nxt;
    logic [2:0]          mask_q, mask_nxt;
    logic                ba_q, ba_nxt;
    logic                idle, accept;
    logic [RW-1:0]       ra_f, rb_f, rc_f, field;
    logic [NUM_REGS-1:0] field_oh;
    logic [NUM_REGS-1:0] gpr_in_d, gpr_out_d;
    logic                r0_zero_d, busy_d, done_d;

    // Handshake: seq_req is taken on any edge where the FSM is IDLE (no separate ready);
    // the requester sees seq_busy during phases and a one-cycle seq_done at the end.
    assign idle     = (state == IDLE);
    assign accept   = idle && seq_req;
    assign ir_nxt   = (idle && ir_ld) ? ir : ir_q;
    assign mask_nxt = accept ? seq_mask : mask_q;
    assign ba_nxt   = accept ? ba_out : ba_q;

    // Fields come from the next IR so a request alongside ir_ld uses the new word.
    assign ra_f = ir_nxt[RA_HI -: RW];
    assign rb_f = ir_nxt[RB_HI -: RW];
    assign rc_f = ir_nxt[RC_HI -: RW];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (idle) begin
            if (seq_req) state_nxt = next_phase(IDLE, seq_mask);
        end else begin
            state_nxt = next_phase(state, mask_q);
        end
    end

    always_comb begin
        field = '0;
        case (state_nxt)
            PH_RB:   field = rb_f;
            PH_RC:   field = rc_f;
            PH_RA:   field = ra_f;
            default: begin
                if (gra)      field = ra_f;
                else if (grb) field = rb_f;
                else if (grc) field = rc_f;
            end
        endcase
    end

    dec_onehot #(.RW(RW), .NUM_REGS(NUM_REGS)) u_dec (
        .sel    (field),
        .onehot (field_oh)
    );

    always_comb begin
        gpr_in_d  = '0;
        gpr_out_d = '0;
        r0_zero_d = 1'b0;
        case (state_nxt)
            PH_RB: begin
                if (ba_nxt && (field == '0)) r0_zero_d = 1'b1;
                else                          gpr_out_d = field_oh;
            end
            PH_RC:   gpr_out_d = field_oh;
            PH_RA:   gpr_in_d  = field_oh;
            default: begin
                // Manual strobes act only in a plain IDLE cycle, never on the accept edge.
                if (idle && !seq_req) begin
                    gpr_in_d  = field_oh & {NUM_REGS{r_in}};
                    gpr_out_d = field_oh & {NUM_REGS{r_out | ba_out}};
                    if (ba_out && (field == '0)) begin
                        gpr_out_d[0] = 1'b0;
                        r0_zero_d    = 1'b1;
                    end
                end
            end
        endcase
        busy_d = (state_nxt != IDLE);
        done_d = ((state_nxt != IDLE) && (next_phase(state_nxt, mask_nxt) == IDLE))
               || (accept && (seq_mask == 3'b000));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir_q     <= '0;
            mask_q   <= '0;
            ba_q     <= 1'b0;
            gpr_in   <= '0;
            gpr_out  <= '0;
            r0_zero  <= 1'b0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            ir_q     <= ir_nxt;
            mask_q   <= mask_nxt;
            ba_q     <= ba_nxt;
            gpr_in   <= gpr_in_d;
            gpr_out  <= gpr_out_d;
            r0_zero  <= r0_zero_d;
            seq_busy <= busy_d;
            seq_done <= done_d;
        end
    end

`ifdef SELECT_ENCODE_ZEXT_EN
    logic zext_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)               zext_q <= 1'b0;
        else if (idle && ir_ld) zext_q <= c_zext;
    end

    assign c_se = zext_q ? {{(REG_SIZE-CONST_W){1'b0}}, ir_q[CONST_W-1:0]}
                         : {{(REG_SIZE-CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};
`else
    assign c_se = {{(REG_SIZE-CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};
`endif

endmodule

// File: tb/tb_select_encode_seq.sv
// Bench for select_encode_seq: vector table through a scoreboard, random manual cycles, clr mid-sequence.
module tb_select_encode_seq;

    localparam int OW = 16 + 16 + 3 + 32;
    localparam logic [31:0] IRA = 32'h0118_8000; // ra=2 rb=3 rc=1
    localparam logic [31:0] IRB = 32'h0004_0000; // ra=0 rb=0 rc=8, const sign bit set
    localparam logic [31:0] CA  = 32'h0000_8000;
    localparam logic [31:0] CB  = 32'hFFFC_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        ir_ld, gra, grb, grc, r_in, r_out, ba_out, seq_req;
    logic [2:0]  seq_mask;
    logic [15:0] gpr_in, gpr_out;
    logic        r0_zero, seq_busy, seq_done;
    logic [31:0] c_se;
`ifdef SELECT_ENCODE_ZEXT_EN
    logic        c_zext = 1'b0;
`endif

    typedef struct {
        logic        ld;
        logic [31:0] ir;
        logic        gra, grb, grc, r_in, r_out, ba_out, req;
        logic [2:0]  mask;
        logic [15:0] gin, gout;
        logic        r0, busy, done;
        logic [31:0] cse;
    } vec_t;

    vec_t            tbl[$];
    logic [OW-1:0]   exp_q[$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    select_encode_seq dut (
        .clk      (clk),
        .clr      (clr),
        .ir       (ir),
        .ir_ld    (ir_ld),
`ifdef SELECT_ENCODE_ZEXT_EN
        .c_zext   (c_zext),
`endif
        .gra      (gra),
        .grb      (grb),
        .grc      (grc),
        .r_in     (r_in),
        .r_out    (r_out),
        .ba_out   (ba_out),
        .seq_req  (seq_req),
        .seq_mask (seq_mask),
        .gpr_in   (gpr_in),
        .gpr_out  (gpr_out),
        .r0_zero  (r0_zero),
        .c_se     (c_se),
        .seq_busy (seq_busy),
        .seq_done (seq_done)
    );

    function automatic vec_t mk(input logic ld, input logic [31:0] irv,
                                input logic a, input logic b, input logic c,
                                input logic wi, input logic ro, input logic ba,
                                input logic rq, input logic [2:0] m,
                                input logic [15:0] gi, input logic [15:0] go,
                                input logic r0, input logic bs, input logic dn,
                                input logic [31:0] cs);
        vec_t v;
        v.ld = ld; v.ir = irv; v.gra = a; v.grb = b; v.grc = c;
        v.r_in = wi; v.r_out = ro; v.ba_out = ba; v.req = rq; v.mask = m;
        v.gin = gi; v.gout = go; v.r0 = r0; v.busy = bs; v.done = dn; v.cse = cs;
        return v;
    endfunction

    function automatic logic [31:0] sext19(input logic [31:0] w);
        logic [18:0] c;
        c = w[18:0];
        return {{13{c[18]}}, c};
    endfunction

    // Reference for one manual IDLE cycle, derived from the default field layout.
    function automatic logic [OW-1:0] model_manual(input logic [31:0] w, input logic a,
                                                   input logic b, input logic c, input logic wi,
                                                   input logic ro, input logic ba);
        logic [3:0]  f;
        logic [15:0] gi, go;
        logic        r0;
        f  = a ? w[26:23] : b ? w[22:19] : c ? w[18:15] : 4'd0;
        gi = wi ? (16'h1 << f) : 16'h0;
        go = (ro || ba) ? (16'h1 << f) : 16'h0;
        r0 = 1'b0;
        if (ba && f == 4'd0) begin
            go = 16'h0;
            r0 = 1'b1;
        end
        return {gi, go, r0, 1'b0, 1'b0, sext19(w)};
    endfunction

    function automatic logic [OW-1:0] observed();
        return {gpr_in, gpr_out, r0_zero, seq_busy, seq_done, c_se};
    endfunction

    task automatic check_val(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ir_ld = v.ld; ir = v.ir; gra = v.gra; grb = v.grb; grc = v.grc;
        r_in = v.r_in; r_out = v.r_out; ba_out = v.ba_out;
        seq_req = v.req; seq_mask = v.mask;
    endtask

    // Drive one cycle, queue its expectation, and compare just after the active edge.
    task automatic apply(input vec_t v, input string name);
        logic [OW-1:0] exp;
        drive(v);
        exp_q.push_back({v.gin, v.gout, v.r0, v.busy, v.done, v.cse});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected queued entry", name, observed());
        end else begin
            exp = exp_q.pop_front();
            check_val(name, observed(), exp);
        end
    endtask

    initial begin
        vec_t          z;
        logic [31:0]   rir;
        logic          a, b, c, wi, ro, ba;
        logic [OW-1:0] exp;

        clr = 1'b1;
        z = mk(0, 32'h0, 0,0,0,0,0,0,0, 3'b000, 16'h0, 16'h0, 0,0,0, 32'h0);
        drive(z);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_state", observed(), '0);
        clr = 1'b0;

        //        ld  ir   a b c wi ro ba rq mask    gin      gout     r0 bs dn cse
        tbl.push_back(mk(1, IRA, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   1,0,0,1,0,0,0, 3'b000, 16'h0004, 16'h0000, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,1,0,0,1,0,0, 3'b000, 16'h0000, 16'h0008, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,1,1,1,0,0, 3'b000, 16'h0002, 16'h0002, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   1,1,0,0,1,0,0, 3'b000, 16'h0000, 16'h0004, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,1,0, 3'b000, 16'h0000, 16'h0000, 1,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,1,0,0, 3'b000, 16'h0000, 16'h0001, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,1,0,0,1,0, 3'b000, 16'h0000, 16'h0002, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,1, 3'b111, 16'h0000, 16'h0008, 0,1,0, CA));
        tbl.push_back(mk(0, 0,   1,0,0,1,0,0,0, 3'b000, 16'h0000, 16'h0002, 0,1,0, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,1, 3'b111, 16'h0004, 16'h0000, 0,1,1, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CA));
        tbl.push_back(mk(1, IRB, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CB));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,1,1, 3'b001, 16'h0000, 16'h0000, 1,1,1, CB));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CB));
        tbl.push_back(mk(1, IRA, 0,0,0,0,0,0,1, 3'b101, 16'h0000, 16'h0008, 0,1,0, CA));
        tbl.push_back(mk(1, IRB, 0,0,0,0,0,0,0, 3'b000, 16'h0004, 16'h0000, 0,1,1, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,1, 3'b000, 16'h0000, 16'h0000, 0,0,1, CA));
        tbl.push_back(mk(0, 0,   0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CA));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl_row%0d", i));

        // Random manual cycles against the reference model.
        for (int k = 0; k < 6; k++) begin
            rir = $urandom();
            apply(mk(1, rir, 0,0,0,0,0,0,0, 3'b000, 16'h0, 16'h0, 0,0,0, sext19(rir)),
                  $sformatf("rnd_load%0d", k));
            for (int j = 0; j < 5; j++) begin
                a  = 1'($urandom_range(0, 1)); b  = 1'($urandom_range(0, 1));
                c  = 1'($urandom_range(0, 1)); wi = 1'($urandom_range(0, 1));
                ro = 1'($urandom_range(0, 1)); ba = 1'($urandom_range(0, 1));
                exp = model_manual(rir, a, b, c, wi, ro, ba);
                apply(mk(0, 32'h0, a,b,c,wi,ro,ba,0, 3'b000,
                         exp[66:51], exp[50:35], exp[34], exp[33], exp[32], exp[31:0]),
                      $sformatf("rnd_manual%0d_%0d", k, j));
            end
        end

        // clr mid-PH_RC: outputs clear at once and no completion pulse follows.
        apply(mk(1, IRA, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0000, 0,0,0, CA), "clr_load");
        apply(mk(0, 0,   0,0,0,0,0,0,1, 3'b111, 16'h0000, 16'h0008, 0,1,0, CA), "clr_ph_rb");
        apply(mk(0, 0,   0,0,0,0,0,0,0, 3'b000, 16'h0000, 16'h0002, 0,1,0, CA), "clr_ph_rc");
        #2;
        clr = 1'b1;
        #1;
        check_val("clr_async", observed(), '0);
        @(posedge clk);
        #1;
        check_val("clr_held", observed(), '0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++)
            apply(z, $sformatf("clr_after%0d", i));

`ifdef SELECT_ENCODE_ZEXT_EN
        c_zext = 1'b1;
        apply(mk(1, IRB, 0,0,0,0,0,0,0, 3'b000, 16'h0, 16'h0, 0,0,0, 32'h0004_0000), "zext_on");
        c_zext = 1'b0;
        apply(mk(1, IRB, 0,0,0,0,0,0,0, 3'b000, 16'h0, 16'h0, 0,0,0, CB), "zext_off");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
